// File: rtl/div_clk_pkg.sv
// Shared definitions for the programmable clock divider: minimum ratio,
// FSM state encoding and the ratio clamp helper.
package div_clk_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ratios below DIV_MIN cannot produce a valid high/low split, so lift them.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        if (v < 32'(DIV_MIN)) begin
            clamp_div = 32'(DIV_MIN);
        end else begin
            clamp_div = v;
        end
    endfunction

endpackage

// File: rtl/div_clk_n_neg_stage.sv
// Negedge half-cycle extension stage. For odd ratios it delays pos_clk by
// half a source period so the OR of both phases is high for H+0.5 cycles.
// For even ratios the output is held low.
module div_clk_neg_stage
    import div_clk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_pos_clk,
    input  logic i_odd,
    output logic o_neg_clk
);

    logic r_neg_clk;

    // Capture pos_clk on the falling edge; cleared asynchronously by rst.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_neg_clk <= 1'b0;
        end else begin
            r_neg_clk <= i_pos_clk & i_odd;
        end
    end

    assign o_neg_clk = r_neg_clk & i_odd;

endmodule

// File: rtl/div_clk_n.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd
// ratios. New ratios are staged in a pending register and only take effect at
// a period boundary, so clk_out never produces a runt pulse.
// Optional feature macro: DIV_CLK_N_TICK_EN (when undefined, tick is tied 0).
module div_clk_n
    import div_clk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             pend
);

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pos_clk;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] r_pending;
    logic             r_pend;

    state_t           w_nstate;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_cur_nxt;
    logic [DIV_W-1:0] w_pending_nxt;
    logic             w_pend_nxt;
    logic             w_pos_nxt;
    logic             w_boundary;
    logic             w_wrap;
    logic [DIV_W-1:0] w_clamped;
    logic             w_neg_clk;

    assign w_clamped = DIV_W'(clamp_div(32'(div_val)));
    assign w_wrap    = (r_cnt == (r_cur_div - DIV_W'(1)));

    // Next-state, counter and ratio staging logic.
    always_comb begin
        w_nstate      = r_state;
        w_cnt_nxt     = r_cnt;
        w_cur_nxt     = r_cur_div;
        w_pend_nxt    = r_pend;
        w_pending_nxt = r_pending;
        w_boundary    = 1'b0;
        case (r_state)
            IDLE: begin
                // Idle is always a boundary: a waiting ratio applies at once.
                w_boundary = 1'b1;
                w_cnt_nxt  = {DIV_W{1'b0}};
                if (en) begin
                    w_nstate = RUN;
                end else begin
                    w_nstate = IDLE;
                end
            end
            RUN: begin
                if (w_wrap) begin
                    w_boundary = 1'b1;
                    w_cnt_nxt  = {DIV_W{1'b0}};
                    if (en) begin
                        w_nstate = RUN;
                    end else begin
                        w_nstate = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            default: begin
                w_nstate  = IDLE;
                w_cnt_nxt = {DIV_W{1'b0}};
            end
        endcase
        // A load coinciding with the boundary defers application by one period.
        if (w_boundary && r_pend && !load) begin
            w_cur_nxt  = r_pending;
            w_pend_nxt = 1'b0;
        end else begin
            w_cur_nxt = r_cur_div;
        end
        if (load) begin
            w_pending_nxt = w_clamped;
            w_pend_nxt    = 1'b1;
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // pos_clk is high while the counter is in the first H = N/2 cycles,
    // evaluated against the ratio that will be in effect next cycle.
    assign w_pos_nxt = (w_nstate == RUN) && (w_cnt_nxt < (w_cur_nxt >> 1));

    // State, counter, positive-phase and ratio registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= {DIV_W{1'b0}};
            r_pos_clk <= 1'b0;
            r_cur_div <= DIV_W'(DEFAULT_DIV);
            r_pending <= DIV_W'(DEFAULT_DIV);
            r_pend    <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_cnt     <= w_cnt_nxt;
            r_pos_clk <= w_pos_nxt;
            r_cur_div <= w_cur_nxt;
            r_pending <= w_pending_nxt;
            r_pend    <= w_pend_nxt;
        end
    end

`ifdef DIV_CLK_N_TICK_EN
    logic r_tick;

    // Period-start strobe, high in the cycle where the counter sits at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= (w_nstate == RUN) && (w_cnt_nxt == {DIV_W{1'b0}});
        end
    end

    assign tick = r_tick;
`else
    assign tick = 1'b0;
`endif

    // Odd/even mode follows cur_div only, so it switches at boundaries.
    div_clk_neg_stage u_neg_stage (
        .clk       (clk),
        .rst       (rst),
        .i_pos_clk (r_pos_clk),
        .i_odd     (r_cur_div[0]),
        .o_neg_clk (w_neg_clk)
    );

    assign clk_out = r_pos_clk | w_neg_clk;
    assign cur_div = r_cur_div;
    assign pend    = r_pend;

endmodule

// File: doc/div_clk_n.md
Name: div_clk_n

Overview:
- Runtime-programmable integer clock divider. Produces a 50%-duty output for both even and odd ratios; odd ratios use a negedge half-cycle extension stage.
- Ratio changes are applied only at period boundaries, so clk_out never emits a runt pulse.
- Sits next to the fixed-ratio dividers as the general clock/strobe source for downstream blocks.

Parameters:
- DIV_W, 8: width of ratio input and internal counter.
- DEFAULT_DIV, 5: ratio loaded on reset. Must be >= 2 and < 2^DIV_W.

Ports:
- clk  input  1  source clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run request, sampled on posedge clk.
- div_val  input  DIV_W  requested divide ratio N.
- load  input  1  single-cycle strobe; captures div_val into pending register.
- clk_out  output  1  divided clock.
- tick  output  1  one-clk-cycle pulse at start of each output period.
- cur_div  output  DIV_W  ratio currently in effect.
- pend  output  1  a loaded ratio is waiting for the period boundary.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, state=IDLE, pos_clk=0, neg_clk=0, clk_out=0, tick=0.
  - cur_div=DEFAULT_DIV, pend=0.
- Ratio clamp: any div_val < 2 (i.e. 0 or 1) is treated as 2 on capture.
- Definitions: N=cur_div, H=floor(N/2).
- States: IDLE, RUN.
  - IDLE -> RUN at posedge with en=1. On that same edge: cnt<=0, pos_clk<=1 (H>=1), tick<=1. clk_out rises at the first posedge where en is sampled high.
  - RUN: cnt increments 0..N-1, then wraps to 0.
  - pos_clk is 1 exactly while cnt < H.
  - tick=1 in the cycle with cnt==0.
  - RUN -> IDLE only at the wrap edge (cnt==N-1) with en=0. cnt is held at 0 and outputs go low. Dropping en mid-period always completes the period.
- Odd N:
  - neg_clk <= pos_clk on negedge clk.
  - clk_out = pos_clk | neg_clk, giving H+0.5 clk periods high and H+0.5 low.
  - neg_clk is reset asynchronously by rst.
- Even N: neg_clk is forced 0; clk_out = pos_clk, giving H high and H low.
- load:
  - Sets pend=1 and stores the clamped div_val into pending.
  - A second load before the boundary overwrites pending (last wins).
- Apply point:
  - In RUN, at the wrap edge: cur_div<=pending, pend<=0. The new period uses the new N immediately.
  - In IDLE: applied on the next posedge.
- load and the wrap edge in the same cycle: the new value is captured into pending and applied at the following boundary. cur_div is not changed this edge.
- The odd/even select is derived from cur_div only, so neg_clk mode switches only at a boundary.
- Reset mid-period: all state clears immediately, and clk_out may truncate. This is permitted only under reset.
- Counter: DIV_W bits, compared against N-1. No overflow because N <= 2^DIV_W-1.

Optional Feature:
- Macro DIV_CLK_N_TICK_EN.
- Defined: tick is generated as described.
- Undefined: tick is tied to 0 and the tick register is not synthesised. All other behaviour is identical.

Decomposition:
- Shared package div_clk_pkg holds:
  - constant DIV_MIN=2;
  - state encoding localparams IDLE/RUN;
  - clamp function returning max(div_val, DIV_MIN).
- One sub-module, div_clk_neg_stage. It contains the negedge flop with async reset and takes inputs pos_clk and odd. It outputs neg_clk, gated by odd.

Test Plan:
- Reset, DEFAULT_DIV=5, en=1: clk_out period = 5 clk. High from posedge to negedge 2.5 clk later. tick every 5 cycles. cur_div=5.
- load div_val=4 mid-period: pend=1 until wrap. Next period is 2 high / 2 low. neg_clk stays 0. cur_div=4, pend=0.
- load div_val=7 then div_val=3 before the boundary: only 3 is applied. Output is 1.5 high / 1.5 low per 3 cycles.
- load div_val=0 and div_val=1: cur_div=2, and clk_out toggles every clk cycle.
- en=0 at cnt=1 with N=6: the period completes through cnt=5, then clk_out=0 and tick=0. en=1 again: clk_out rises on the first sampled edge.
- rst asserted asynchronously mid-high phase with N=5: clk_out goes 0 immediately without waiting for a clock edge. After release with en=1, a clean 5-cycle period follows with cur_div=5.
